// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbiter sequencing the 8-bit async board SRAM between video word reads and buffered download writes
// Reads fetch 4 big-endian bytes; writes drain a small FIFO with registered we_n/oe strobes.

module sram_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 4,
    parameter int WE_CYCLES    = 1,
    parameter int MAX_RD_BURST = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-3:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STK_W = (MAX_RD_BURST > 1) ? $clog2(MAX_RD_BURST + 1) : 1;
    localparam int ENT_W = ADDR_W + 8;

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        RD4,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wr_ptr;
    logic [PTR_W-1:0]  fifo_rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_count_next;
    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic              rd_pend;
    logic [ADDR_W-3:0] rd_pend_addr;
    logic [STK_W-1:0]  rd_streak;
    logic [2:0]        we_cnt;

    logic              rd_win;
    logic              wr_win;
    logic              rd_grant;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[fifo_rd_ptr];
    assign push       = wr_req && (fifo_count != CNT_W'(FIFO_DEPTH));

    // Reads yield to a waiting write only once the burst allowance is used up.
    assign rd_win   = rd_pend && (fifo_empty || (rd_streak < STK_W'(MAX_RD_BURST)));
    assign wr_win   = !rd_win && !fifo_empty;
    assign rd_grant = (state == IDLE) && rd_win;
    assign pop      = (state == IDLE) && wr_win;

    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + CNT_W'(1);
            2'b01:   fifo_count_next = fifo_count - CNT_W'(1);
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_win) begin
                    state_next = RD1;
                end else if (wr_win) begin
                    state_next = WR_SETUP;
                end
            end
            RD0:      state_next = RD1;
            RD1:      state_next = RD2;
            RD2:      state_next = RD3;
            RD3:      state_next = RD4;
            RD4:      state_next = IDLE;
            WR_SETUP: state_next = WR_PULSE;
            WR_PULSE: begin
                if (we_cnt == 3'd0) begin
                    state_next = WR_HOLD;
                end
            end
            WR_HOLD:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            wr_full     <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count_next;
            wr_full    <= (fifo_count_next == CNT_W'(FIFO_DEPTH));
            if (wr_req && !push) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // A fresh request on the grant edge must survive the grant clearing rd_pend.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_pend      <= 1'b0;
            rd_pend_addr <= '0;
        end else if (rd_req) begin
            rd_pend      <= 1'b1;
            rd_pend_addr <= rd_addr;
        end else if (rd_grant) begin
            rd_pend      <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_streak  <= '0;
            we_cnt     <= '0;
        end else begin
            rd_valid   <= (state == RD4);
            // Strobes follow the next state so they change only on the clock edge.
            sram_we_n  <= (state_next != WR_PULSE);
            sram_dq_oe <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                          (state_next == WR_HOLD);
            case (state)
                IDLE: begin
                    if (rd_grant) begin
                        sram_addr <= {rd_pend_addr, 2'b00};
                        if (rd_streak != STK_W'(MAX_RD_BURST)) begin
                            rd_streak <= rd_streak + STK_W'(1);
                        end
                    end else if (pop) begin
                        sram_addr <= fifo_head[ENT_W-1:8];
                        sram_dq_o <= fifo_head[7:0];
                        rd_streak <= '0;
                        we_cnt    <= 3'(WE_CYCLES - 1);
                    end
                end
                RD1: begin
                    rd_data[31:24] <= sram_dq_i;
                    sram_addr[1:0] <= 2'b01;
                end
                RD2: begin
                    rd_data[23:16] <= sram_dq_i;
                    sram_addr[1:0] <= 2'b10;
                end
                RD3: begin
                    rd_data[15:8]  <= sram_dq_i;
                    sram_addr[1:0] <= 2'b11;
                end
                RD4: begin
                    rd_data[7:0]   <= sram_dq_i;
                end
                WR_PULSE: begin
                    if (we_cnt != 3'd0) begin
                        we_cnt <= we_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter with a behavioural async SRAM

module tb_sram_arbiter;

    localparam int ADDR_W = 19;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-3:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_full;
    logic              wr_overflow;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dq_o;
    logic              sram_dq_oe;
    logic [7:0]        sram_dq_i;
    logic              sram_we_n;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int         total = 0;
    int         bad = 0;
    int         viol = 0;
    logic [7:0] wr_log_d[$];
    byte        ev_q[$];
    logic       prev_we_n = 1'b1;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0] prev_dq;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .WE_CYCLES(1), .MAX_RD_BURST(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_overflow(wr_overflow),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    always #5 clk_sys = ~clk_sys;

    assign sram_dq_i = mem[sram_addr];

    // SRAM model: byte stored while we_n is low; address/data must hold steady during the pulse.
    always @(negedge clk_sys) begin
        if (sram_we_n === 1'b0) begin
            if (sram_dq_oe !== 1'b1) viol++;
            if (prev_we_n === 1'b0 && (sram_addr !== prev_addr || sram_dq_o !== prev_dq)) viol++;
            if (prev_we_n === 1'b1) begin
                wr_log_d.push_back(sram_dq_o);
                ev_q.push_back("W");
            end
            mem[sram_addr] = sram_dq_o;
        end
        if (rd_valid === 1'b1) ev_q.push_back("R");
        prev_we_n = sram_we_n;
        prev_addr = sram_addr;
        prev_dq   = sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int          pulses;
    int          n0;
    int          wcount;
    int          run;
    int          max_run;
    logic [31:0] cap;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem[32'h40 + i]  = 8'(8'h40 + i);
            mem[32'h800 + i] = 8'(8'h11 * (i + 1));
            mem[32'h400 + i] = 8'hEE;
        end
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        ticks(3);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_overflow", {31'd0, wr_overflow}, 32'd0);
        check("rst_full", {31'd0, wr_full}, 32'd0);
        reset = 1'b0;
        tick();

        // Word read: captured at edge T, rd_valid sampled high by edge T+6.
        rd_req = 1'b1; rd_addr = 17'h00010;
        tick();
        rd_req = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) begin
                check("rd_valid_latency", {31'd0, rd_valid}, 32'd1);
                check("rd_data_word", rd_data, 32'h40414243);
            end
            if (rd_valid) pulses++;
        end
        check("rd_valid_pulses", 32'(pulses), 32'd1);
        check("rd_no_write", 32'(wr_log_d.size()), 32'd0);

        // Single write, WE_CYCLES=1.
        wr_req = 1'b1; wr_addr = 19'h12345; wr_data = 8'hA5;
        tick();
        wr_req = 1'b0;
        tick();
        check("wr_setup_addr", 32'(sram_addr), 32'h12345);
        check("wr_setup_dq", 32'(sram_dq_o), 32'hA5);
        check("wr_setup_oe", {31'd0, sram_dq_oe}, 32'd1);
        check("wr_setup_we_n", {31'd0, sram_we_n}, 32'd1);
        tick();
        check("wr_pulse_we_n", {31'd0, sram_we_n}, 32'd0);
        tick();
        check("wr_hold_we_n", {31'd0, sram_we_n}, 32'd1);
        check("wr_hold_oe", {31'd0, sram_dq_oe}, 32'd1);
        tick();
        check("wr_idle_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("wr_mem", 32'(mem[19'h12345]), 32'hA5);
        check("wr_one_pulse", 32'(wr_log_d.size()), 32'd1);

        // Fairness: reads every 6 cycles with three queued writes.
        ev_q.delete();
        n0 = wr_log_d.size();
        for (int c = 0; c < 48; c++) begin
            rd_req  = (c % 6 == 0);
            rd_addr = 17'(17'h20 + c);
            wr_req  = (c >= 1 && c <= 3);
            wr_addr = 19'(19'h300 + c);
            wr_data = 8'(8'h10 + c);
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b0;
        ticks(40);
        wcount = 0; run = 0; max_run = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i] == "W") begin
                if (wcount > 0 && run > max_run) max_run = run;
                wcount++;
                run = 0;
            end else begin
                run++;
            end
        end
        check("fair_writes", 32'(wcount), 32'd3);
        check("fair_burst_le2", 32'(max_run <= 2), 32'd1);
        check("fair_byte0", 32'(wr_log_d[n0]), 32'h11);
        check("fair_byte1", 32'(wr_log_d[n0 + 1]), 32'h12);
        check("fair_byte2", 32'(wr_log_d[n0 + 2]), 32'h13);
        check("fair_overflow", {31'd0, wr_overflow}, 32'd0);

        // Overflow: five pushes during a read, depth 4.
        n0 = wr_log_d.size();
        rd_req = 1'b1; rd_addr = 17'h00010;
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_req = 1'b1; wr_addr = 19'(19'h500 + k); wr_data = 8'(8'h50 + k);
            tick();
            if (k == 3) check("ovf_full_after4", {31'd0, wr_full}, 32'd1);
            if (k == 4) check("ovf_sticky", {31'd0, wr_overflow}, 32'd1);
        end
        wr_req = 1'b0;
        ticks(40);
        check("ovf_four_writes", 32'(wr_log_d.size() - n0), 32'd4);
        check("ovf_last_kept", 32'(mem[19'h503]), 32'h53);
        check("ovf_dropped", 32'(mem[19'h504]), 32'h00);
        check("ovf_full_drained", {31'd0, wr_full}, 32'd0);
        check("ovf_still_set", {31'd0, wr_overflow}, 32'd1);

        // Two read requests before the grant: latest address wins.
        wr_req = 1'b1; wr_addr = 19'h700; wr_data = 8'h77;
        tick();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 17'h100;
        tick();
        rd_addr = 17'h200;
        tick();
        rd_req = 1'b0;
        pulses = 0; cap = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd_valid) begin
                pulses++;
                cap = rd_data;
            end
        end
        check("merge_one_valid", 32'(pulses), 32'd1);
        check("merge_data", cap, 32'h11223344);

        // Reset while we_n is low, with one more write queued.
        wr_req = 1'b1; wr_addr = 19'h600; wr_data = 8'h66;
        tick();
        wr_addr = 19'h601; wr_data = 8'h67;
        tick();
        wr_req = 1'b0;
        tick();
        check("pre_rst_we_low", {31'd0, sram_we_n}, 32'd0);
        reset = 1'b1;
        tick();
        check("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_mid_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_mid_full", {31'd0, wr_full}, 32'd0);
        check("rst_mid_overflow", {31'd0, wr_overflow}, 32'd0);
        check("rst_mid_addr", 32'(sram_addr), 32'd0);
        n0 = wr_log_d.size();
        reset = 1'b0;
        ticks(20);
        check("rst_no_activity", 32'(wr_log_d.size()), 32'(n0));
        check("rst_idle_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("we_stable", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the single 8-bit asynchronous board SRAM (19-bit address) between two requesters.
- Requester 1 is the video fetch port: 32-bit pixel word read as 4 consecutive bytes, big-endian.
- Requester 2 is the download writer: single-byte writes from data_io, buffered in a small FIFO so download bytes are never lost while video reads run.
- Sits between the pixel address generator / data_io logic and the SRAM pins; replaces ad-hoc inline SRAM state logic in the top level.

Parameters:
- ADDR_W, 19: SRAM byte address width.
- FIFO_DEPTH, 4: write FIFO entries; power of 2, minimum 2.
- WE_CYCLES, 1: cycles sram_we_n is held low per write, 1..7.
- MAX_RD_BURST, 2: maximum consecutive reads granted while the write FIFO is non-empty.

Ports:
- clk_sys  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- rd_req  in  1  one-cycle pulse; request word read.
- rd_addr  in  ADDR_W-2  word address; byte address is {rd_addr,2'b00}.
- rd_data  out  32  byte0 in [31:24] … byte3 in [7:0].
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- wr_req  in  1  one-cycle pulse; push a write.
- wr_addr  in  ADDR_W  byte address.
- wr_data  in  8  write byte.
- wr_full  out  1  FIFO holds FIFO_DEPTH entries.
- wr_overflow  out  1  sticky: a wr_req was dropped.
- sram_addr  out  ADDR_W  SRAM address pins.
- sram_dq_o  out  8  write data.
- sram_dq_oe  out  1  1 = drive sram_dq_o onto the SRAM data bus.
- sram_dq_i  in  8  SRAM data bus input.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:

Reset (synchronous, highest priority, valid mid-operation):
- Outputs: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, rd_data=0, rd_valid=0, wr_overflow=0.
- Internal: FIFO empty, rd_pend=0, rd_streak=0, state=IDLE.
- A write in progress is aborted; we_n is high after the reset edge.

Read capture:
- rd_req sets rd_pend and latches rd_addr into rd_pend_addr.
- A second rd_req before the grant overwrites rd_pend_addr: latest address wins, single read.

Write FIFO:
- wr_req with FIFO not full pushes {wr_addr,wr_data}.
- wr_req with FIFO full drops the data and sets wr_overflow. It stays set until reset.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- wr_full is registered and equals (count==FIFO_DEPTH).

State machine:
- IDLE; RD0, RD1, RD2, RD3, RD4; WR_SETUP; WR_PULSE; WR_HOLD.
- IDLE, arbitration evaluated every cycle. Read is chosen if rd_pend and (FIFO empty or rd_streak<MAX_RD_BURST). Otherwise write is chosen if FIFO non-empty. Otherwise stay in IDLE.
- A rd_req in the same cycle is captured but arbitrated on the next cycle.
- Read grant: sram_addr<={rd_pend_addr,00}, clear rd_pend, rd_streak++ (saturating), go to RD1.
- RD1–RD3: latch sram_dq_i into byte n-1 of rd_data, advance the low address bits to 01, 10, 11.
- RD4: latch byte3; assert rd_valid for exactly one cycle (registered, high in the cycle after RD4); return to IDLE.
- Read latency: rd_req at edge T with idle FSM and empty FIFO gives rd_valid high for cycle T+6, i.e. 1 capture + 5 FSM cycles.
- sram_dq_oe=0 throughout reads.
- Write grant: pop the FIFO head, rd_streak<=0, go to WR_SETUP.
- WR_SETUP: sram_addr and sram_dq_o set, sram_dq_oe=1, we_n=1.
- WR_PULSE: we_n=0 for WE_CYCLES cycles.
- WR_HOLD: we_n=1, oe stays 1, address and data stable.
- Next IDLE: oe=0.
- A write occupies WE_CYCLES+2 cycles plus 1 IDLE cycle.
- Address and data never change while we_n=0.
- sram_we_n and sram_dq_oe are registered outputs, glitch-free.

Fairness:
- With continuous reads and a non-empty FIFO, at most MAX_RD_BURST reads occur between writes.
- Reads are never starved by writes: after a write, a pending read wins.

Test Plan:
- Reset, then rd_req addr=0x00010 with SRAM model bytes 0x40..0x43 at 0x40 → rd_valid one pulse at T+6, rd_data=0x40414243, sram_we_n stays 1.
- wr_req addr=0x12345 data=0xA5, no reads → sram_addr=0x12345, dq_o=0xA5, oe=1, we_n low exactly WE_CYCLES cycles with addr/data stable, then oe=0; model holds 0xA5.
- rd_req every 6 cycles plus 3 wr_req back-to-back → at most 2 reads between consecutive writes; all 3 bytes written in order; wr_overflow=0.
- 5 wr_req in consecutive cycles during a read (DEPTH 4) → wr_full=1 after the 4th push, 5th dropped, wr_overflow=1; only 4 bytes reach SRAM.
- Two rd_req (addr 0x100 then 0x200) before grant → single read of byte addresses 0x800..0x803, one rd_valid.
- Assert reset during WR_PULSE → we_n=1, oe=0 after the reset edge; FIFO empty, wr_full=0; no further SRAM activity.
